// File: rtl/vending_ctrl_multi.sv
// Multi-product vending controller.
// Collects coins into a binary credit register and sells one of N_PROD
// products, each with its own price. Change and cancelled credit are paid
// back one coin per cycle, always using the largest coin that fits.
module vending_ctrl_multi #(
  parameter int                         N_PROD     = 4,
  parameter int                         CREDIT_W   = 8,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {8'd10, 8'd7, 8'd5, 8'd3},
  parameter int                         MAX_CREDIT = 50,
  localparam int                        SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic                clk50m,
  input  logic                rst,
  input  logic                new_coin,
  input  logic [3:0]          coin,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  input  logic                door,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   bottle,
  output logic                unlock,
  output logic                change_valid,
  output logic [3:0]          change_coin,
  output logic                coin_reject,
  output logic                insufficient
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    VEND      = 3'd2,
    DOOR_OPEN = 3'd3,
    CHANGE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] remaining_q, remaining_d;
  logic [N_PROD-1:0]   bottle_q, bottle_d;
  logic                unlock_q, unlock_d;
  logic                change_valid_q, change_valid_d;
  logic [3:0]          change_coin_q, change_coin_d;
  logic                coin_reject_q, coin_reject_d;
  logic                insufficient_q, insufficient_d;

  logic [CREDIT_W-1:0] price;
  logic                sel_ok;
  logic                coin_legal;
  logic [CREDIT_W:0]   coin_sum;
  logic                coin_fits;
  logic [3:0]          chg_val;

  // Look up the price of the selected product; out-of-range indices are flagged.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < N_PROD; i++) begin
      if (int'(sel) == i) begin
        price  = PRICES[i*CREDIT_W +: CREDIT_W];
        sel_ok = 1'b1;
      end
    end
  end

  // Coin legality and overflow check against the credit ceiling (one extra bit for the carry).
  assign coin_legal = (coin == 4'd1) || (coin == 4'd2) || (coin == 4'd5) || (coin == 4'd10);
  assign coin_sum   = {1'b0, credit_q} + (CREDIT_W + 1)'(coin);
  assign coin_fits  = coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT);

  // Largest change coin not exceeding the remaining amount.
  always_comb begin
    if (remaining_q >= CREDIT_W'(10))     chg_val = 4'd10;
    else if (remaining_q >= CREDIT_W'(5)) chg_val = 4'd5;
    else if (remaining_q >= CREDIT_W'(2)) chg_val = 4'd2;
    else if (remaining_q != '0)           chg_val = 4'd1;
    else                                  chg_val = 4'd0;
  end

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    remaining_d    = remaining_q;
    bottle_d       = '0;
    unlock_d       = 1'b0;
    change_valid_d = 1'b0;
    change_coin_d  = 4'd0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;

    case (state_q)
      IDLE, COLLECT: begin
        // cancel beats new_coin beats sel_valid; the losers are dropped silently.
        if (cancel && (state_q == COLLECT)) begin
          remaining_d = credit_q;
          credit_d    = '0;
          state_d     = CHANGE;
        end else if (new_coin) begin
          if (coin_legal && coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = COLLECT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (sel_valid) begin
          if ((state_q == COLLECT) && sel_ok && (credit_q >= price)) begin
            remaining_d = credit_q - price;
            credit_d    = '0;
            state_d     = VEND;
            unlock_d    = 1'b1;
            // bottle_q doubles as the latched selection for VEND/DOOR_OPEN.
            for (int i = 0; i < N_PROD; i++) bottle_d[i] = (int'(sel) == i);
          end else begin
            insufficient_d = 1'b1;
          end
        end
      end

      VEND: begin
        bottle_d      = bottle_q;
        unlock_d      = 1'b1;
        coin_reject_d = new_coin;
        if (door) state_d = DOOR_OPEN;
      end

      DOOR_OPEN: begin
        coin_reject_d = new_coin;
        if (!door) begin
          state_d = CHANGE;
        end else begin
          bottle_d = bottle_q;
          unlock_d = 1'b1;
        end
      end

      CHANGE: begin
        coin_reject_d = new_coin;
        if (remaining_q == '0) begin
          state_d = IDLE;
        end else begin
          change_valid_d = 1'b1;
          change_coin_d  = chg_val;
          remaining_d    = remaining_q - CREDIT_W'(chg_val);
        end
      end

      default: begin
        state_d     = IDLE;
        credit_d    = '0;
        remaining_d = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset; reset discards any credit owed.
  always_ff @(posedge clk50m) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      remaining_q    <= '0;
      bottle_q       <= '0;
      unlock_q       <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 4'd0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      remaining_q    <= remaining_d;
      bottle_q       <= bottle_d;
      unlock_q       <= unlock_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  assign credit       = credit_q;
  assign bottle       = bottle_q;
  assign unlock       = unlock_q;
  assign change_valid = change_valid_q;
  assign change_coin  = change_coin_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;

endmodule

// File: tb/tb_vending_ctrl_multi.sv
// Directed testbench for vending_ctrl_multi with default parameters
// (prices p0=3, p1=5, p2=7, p3=10, MAX_CREDIT=50).
module tb_vending_ctrl_multi;

  logic       clk50m = 1'b0;
  logic       rst = 1'b1;
  logic       new_coin = 1'b0;
  logic [3:0] coin = 4'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       cancel = 1'b0;
  logic       door = 1'b0;
  logic [7:0] credit;
  logic [3:0] bottle;
  logic       unlock;
  logic       change_valid;
  logic [3:0] change_coin;
  logic       coin_reject;
  logic       insufficient;
  logic [19:0] all_out;

  int n_cmp = 0;
  int n_err = 0;

  vending_ctrl_multi dut (
    .clk50m       (clk50m),
    .rst          (rst),
    .new_coin     (new_coin),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .door         (door),
    .credit       (credit),
    .bottle       (bottle),
    .unlock       (unlock),
    .change_valid (change_valid),
    .change_coin  (change_coin),
    .coin_reject  (coin_reject),
    .insufficient (insufficient)
  );

  always #10 clk50m = ~clk50m;

  assign all_out = {credit, bottle, unlock, change_valid, change_coin, coin_reject, insufficient};

  // Advance one clock; outputs are then observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic put_coin(input logic [3:0] v);
    new_coin = 1'b1; coin = v;
    tick();
    new_coin = 1'b0; coin = 4'd0;
  endtask

  task automatic select(input logic [1:0] s);
    sel_valid = 1'b1; sel = s;
    tick();
    sel_valid = 1'b0; sel = 2'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (all_out !== 20'd0) begin n_err++; $display("FAIL reset_outputs: got %h want 00000", all_out); end
  endtask

  task automatic test_exact_pay();
    do_reset();
    put_coin(4'd2);
    n_cmp++; if (credit !== 8'd2) begin n_err++; $display("FAIL exact_credit2: got %0d want 2", credit); end
    put_coin(4'd5);
    n_cmp++; if (credit !== 8'd7) begin n_err++; $display("FAIL exact_credit7: got %0d want 7", credit); end
    select(2'd2);
    n_cmp++; if ({bottle, unlock, credit} !== {4'b0100, 1'b1, 8'd0}) begin n_err++;
      $display("FAIL exact_vend: got bottle=%b unlock=%b credit=%0d want 0100 1 0", bottle, unlock, credit); end
    door = 1'b1; tick();
    n_cmp++; if ({bottle, unlock} !== {4'b0100, 1'b1}) begin n_err++;
      $display("FAIL exact_door_open: got bottle=%b unlock=%b want 0100 1", bottle, unlock); end
    door = 1'b0; tick();
    n_cmp++; if ({bottle, unlock, change_valid} !== 6'd0) begin n_err++;
      $display("FAIL exact_change_entry: got bottle=%b unlock=%b cv=%b want 0 0 0", bottle, unlock, change_valid); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== 5'd0) begin n_err++;
      $display("FAIL exact_no_change: got cv=%b coin=%0d want 0 0", change_valid, change_coin); end
    put_coin(4'd1);
    n_cmp++; if ({credit, coin_reject} !== {8'd1, 1'b0}) begin n_err++;
      $display("FAIL exact_back_idle: got credit=%0d rej=%b want 1 0", credit, coin_reject); end
  endtask

  task automatic test_overpay();
    do_reset();
    put_coin(4'd10); put_coin(4'd10);
    n_cmp++; if (credit !== 8'd20) begin n_err++; $display("FAIL over_credit: got %0d want 20", credit); end
    select(2'd1);
    n_cmp++; if ({bottle, unlock, credit} !== {4'b0010, 1'b1, 8'd0}) begin n_err++;
      $display("FAIL over_vend: got bottle=%b unlock=%b credit=%0d want 0010 1 0", bottle, unlock, credit); end
    door = 1'b1; tick();
    door = 1'b0; tick();
    n_cmp++; if (change_valid !== 1'b0) begin n_err++; $display("FAIL over_entry: got cv=%b want 0", change_valid); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== {1'b1, 4'd10}) begin n_err++;
      $display("FAIL over_chg10: got cv=%b coin=%0d want 1 10", change_valid, change_coin); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== {1'b1, 4'd5}) begin n_err++;
      $display("FAIL over_chg5: got cv=%b coin=%0d want 1 5", change_valid, change_coin); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== 5'd0) begin n_err++;
      $display("FAIL over_done: got cv=%b coin=%0d want 0 0", change_valid, change_coin); end
  endtask

  task automatic test_cancel();
    logic [3:0] exp_coins [3];
    exp_coins = '{4'd5, 4'd2, 4'd1};
    do_reset();
    put_coin(4'd5); put_coin(4'd2); put_coin(4'd1);
    n_cmp++; if (credit !== 8'd8) begin n_err++; $display("FAIL cancel_credit: got %0d want 8", credit); end
    cancel = 1'b1; tick(); cancel = 1'b0;
    n_cmp++; if ({credit, change_valid} !== 9'd0) begin n_err++;
      $display("FAIL cancel_entry: got credit=%0d cv=%b want 0 0", credit, change_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({change_valid, change_coin, bottle, unlock} !== {1'b1, exp_coins[i], 4'b0000, 1'b0}) begin n_err++;
        $display("FAIL cancel_chg%0d: got cv=%b coin=%0d bottle=%b unlock=%b want 1 %0d 0000 0",
                 i, change_valid, change_coin, bottle, unlock, exp_coins[i]); end
    end
    tick();
    n_cmp++; if (change_valid !== 1'b0) begin n_err++; $display("FAIL cancel_done: got cv=%b want 0", change_valid); end
  endtask

  task automatic test_refusals();
    do_reset();
    put_coin(4'd3);
    n_cmp++; if ({coin_reject, credit} !== {1'b1, 8'd0}) begin n_err++;
      $display("FAIL rej_illegal: got rej=%b credit=%0d want 1 0", coin_reject, credit); end
    tick();
    n_cmp++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL rej_one_cycle: got %b want 0", coin_reject); end
    for (int i = 0; i < 4; i++) put_coin(4'd10);
    put_coin(4'd5);
    n_cmp++; if (credit !== 8'd45) begin n_err++; $display("FAIL rej_credit45: got %0d want 45", credit); end
    put_coin(4'd10);
    n_cmp++; if ({coin_reject, credit} !== {1'b1, 8'd45}) begin n_err++;
      $display("FAIL rej_overflow: got rej=%b credit=%0d want 1 45", coin_reject, credit); end
    put_coin(4'd5);
    n_cmp++; if ({coin_reject, credit} !== {1'b0, 8'd50}) begin n_err++;
      $display("FAIL rej_max_ok: got rej=%b credit=%0d want 0 50", coin_reject, credit); end

    do_reset();
    put_coin(4'd2); put_coin(4'd1);
    select(2'd3);
    n_cmp++; if ({insufficient, credit, bottle} !== {1'b1, 8'd3, 4'b0000}) begin n_err++;
      $display("FAIL insuff_p3: got ins=%b credit=%0d bottle=%b want 1 3 0000", insufficient, credit, bottle); end
    select(2'd0);
    n_cmp++; if ({insufficient, bottle, credit} !== {1'b0, 4'b0001, 8'd0}) begin n_err++;
      $display("FAIL exact_p0: got ins=%b bottle=%b credit=%0d want 0 0001 0", insufficient, bottle, credit); end
    put_coin(4'd1);
    n_cmp++; if ({coin_reject, credit, bottle} !== {1'b1, 8'd0, 4'b0001}) begin n_err++;
      $display("FAIL rej_vend: got rej=%b credit=%0d bottle=%b want 1 0 0001", coin_reject, credit, bottle); end

    do_reset();
    select(2'd0);
    n_cmp++; if (insufficient !== 1'b1) begin n_err++; $display("FAIL insuff_idle: got %b want 1", insufficient); end
  endtask

  task automatic test_coincident();
    do_reset();
    put_coin(4'd5);
    new_coin = 1'b1; coin = 4'd2; sel_valid = 1'b1; sel = 2'd1;
    tick();
    new_coin = 1'b0; coin = 4'd0; sel_valid = 1'b0; sel = 2'd0;
    n_cmp++; if ({credit, bottle, unlock, insufficient} !== {8'd7, 4'b0000, 1'b0, 1'b0}) begin n_err++;
      $display("FAIL coin_over_sel: got credit=%0d bottle=%b unlock=%b ins=%b want 7 0000 0 0",
               credit, bottle, unlock, insufficient); end
    cancel = 1'b1; new_coin = 1'b1; coin = 4'd10;
    tick();
    cancel = 1'b0; new_coin = 1'b0; coin = 4'd0;
    n_cmp++; if ({credit, coin_reject} !== {8'd0, 1'b0}) begin n_err++;
      $display("FAIL cancel_over_coin: got credit=%0d rej=%b want 0 0", credit, coin_reject); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== {1'b1, 4'd5}) begin n_err++;
      $display("FAIL coinc_chg5: got cv=%b coin=%0d want 1 5", change_valid, change_coin); end
    tick();
    n_cmp++; if ({change_valid, change_coin} !== {1'b1, 4'd2}) begin n_err++;
      $display("FAIL coinc_chg2: got cv=%b coin=%0d want 1 2", change_valid, change_coin); end
    tick();
    n_cmp++; if (change_valid !== 1'b0) begin n_err++; $display("FAIL coinc_done: got cv=%b want 0", change_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    put_coin(4'd10);
    select(2'd0);
    door = 1'b1; tick();
    door = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (all_out !== 20'd0) begin n_err++; $display("FAIL rst_door_open: got %h want 00000", all_out); end
    put_coin(4'd1);
    n_cmp++; if ({credit, coin_reject} !== {8'd1, 1'b0}) begin n_err++;
      $display("FAIL rst_door_idle: got credit=%0d rej=%b want 1 0", credit, coin_reject); end

    do_reset();
    put_coin(4'd10); put_coin(4'd5); put_coin(4'd2);
    cancel = 1'b1; tick(); cancel = 1'b0;
    tick();
    n_cmp++; if ({change_valid, change_coin} !== {1'b1, 4'd10}) begin n_err++;
      $display("FAIL rst_pre_chg: got cv=%b coin=%0d want 1 10", change_valid, change_coin); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (all_out !== 20'd0) begin n_err++; $display("FAIL rst_mid_change: got %h want 00000", all_out); end
    tick();
    n_cmp++; if ({change_valid, credit} !== 9'd0) begin n_err++;
      $display("FAIL rst_no_more_change: got cv=%b credit=%0d want 0 0", change_valid, credit); end
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_overpay();
    test_cancel();
    test_refusals();
    test_coincident();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vending_ctrl_multi.md
Name: vending_ctrl_multi

Overview:
Parametrised successor of the single-product coin FSM. Accepts coins into a binary credit register and serves N_PROD products with individually parametrised prices. Returns change and cancelled credit one coin per cycle. Sits between the coin validator front end and the door/dispenser actuators in the vending subsystem.

Parameters:
N_PROD, 4, number of products (bottle channels), 1..8
CREDIT_W, 8, credit register width
PRICES, {8'd10,8'd7,8'd5,8'd3}, packed N_PROD*CREDIT_W prices; slice i = price of product i (default: p0=3, p1=5, p2=7, p3=10)
MAX_CREDIT, 50, highest credit accepted; must be < 2**CREDIT_W

Ports:
clk50m  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
new_coin  in  1  one-cycle strobe, coin valid
coin  in  4  coin value; legal values 1, 2, 5, 10
sel_valid  in  1  one-cycle product-selection strobe
sel  in  $clog2(N_PROD)  selected product index
cancel  in  1  one-cycle strobe, return all credit
door  in  1  1 = door open
credit  out  CREDIT_W  current credit (registered)
bottle  out  N_PROD  one-hot release of the selected product
unlock  out  1  door unlock
change_valid  out  1  one change coin issued this cycle
change_coin  out  4  value of issued change coin (10/5/2/1), 0 when !change_valid
coin_reject  out  1  one-cycle pulse: coin refused
insufficient  out  1  one-cycle pulse: selection refused for lack of credit

Behaviour:
- Reset: state IDLE, credit=0, remaining=0, bottle=0, unlock=0, change_valid=0, change_coin=0, coin_reject=0, insufficient=0. Reset in any state (including mid-change) discards credit; no change is paid.
- All outputs registered; pulses last exactly one cycle, issued the cycle after the causing strobe.
- States: IDLE, COLLECT, VEND, DOOR_OPEN, CHANGE.
- Coin acceptance (IDLE/COLLECT only): legal coin and credit+coin <= MAX_CREDIT -> credit += coin next cycle, IDLE->COLLECT. Illegal value or overflow -> coin_reject, credit unchanged. new_coin in VEND/DOOR_OPEN/CHANGE -> coin_reject.
- Priority in COLLECT when strobes coincide: cancel > new_coin > sel_valid. The lower-priority strobe is dropped (sel_valid with new_coin is ignored; no insufficient pulse).
- cancel in COLLECT: remaining=credit, credit=0, -> CHANGE. cancel in IDLE has no effect. Ignored elsewhere.
- sel_valid in COLLECT: compared against the registered credit. credit >= PRICES[sel] -> latch sel, remaining = credit - price, credit=0, -> VEND. Otherwise -> insufficient pulse, stay COLLECT. sel >= N_PROD -> insufficient. sel_valid in IDLE -> insufficient.
- VEND: bottle[sel_latched]=1, unlock=1. door=1 -> DOOR_OPEN.
- DOOR_OPEN: bottle and unlock held. door=0 -> CHANGE (bottle, unlock drop on entry). No timeout; VEND waits indefinitely.
- CHANGE: each cycle with remaining>0, issue the largest of {10,5,2,1} <= remaining. change_valid=1, change_coin=value, remaining -= value. remaining==0 -> IDLE; change_valid=0 in the IDLE cycle. Entry with remaining==0 -> IDLE next cycle with no change pulse.
- Change takes ceil-greedy cycles. Example: 18 -> 10,5,2,1 (4 cycles).
- Unreachable state encodings -> IDLE, outputs 0.

Test Plan:
- Exact pay: coins 2,5 -> credit 7; sel=2 -> next cycle bottle=4'b0100, unlock=1, credit=0; door 1 then 0 -> CHANGE -> IDLE next cycle, no change_valid.
- Overpay: coins 10,10 (credit 20); sel=1 (price 5) -> VEND; after door cycle, change_coin 10 then 5 on consecutive cycles with change_valid=1, then IDLE.
- Cancel: coins 5,2,1 (credit 8); cancel -> credit 0, change 5,2,1 over 3 cycles; bottle and unlock stay 0.
- Refusals: coin=3 -> coin_reject, credit unchanged. Credit 45 + coin 10 -> coin_reject, credit 45. Credit 3, sel=3 -> insufficient, stay COLLECT. Coin during VEND -> coin_reject.
- Coincident strobes: credit 5 with new_coin(2)+sel_valid(sel=1) same cycle -> credit 7, no VEND, no insufficient. cancel+new_coin -> cancel wins; the coin is neither credited nor rejected.
- Reset mid-operation: assert rst during DOOR_OPEN, and again mid-CHANGE -> all outputs 0 next cycle, credit 0, state IDLE.
